mult_share_ctrl: RTL and testbench

Controller that time-shares one registered Wallace-tree multiplier datapath among NUM_REQ requesters. Round-robin arbitration accepts at most one operand pair per cycle. Signed operands are converted to magnitudes before the unsigned multiplier, and the sign is restored on the result. A tag pipeline matched to the multiplier latency returns each product with its requester id.

---
 rtl/mult_share_pkg.sv | 14 +
 rtl/mult_share_rr_arbiter.sv | 26 ++
 rtl/mult_share_ctrl.sv | 81 ++++++++
 tb/tb_mult_share_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mult_share_pkg.sv
// mult_share_pkg: shared widths, in-flight tag type and magnitude helper for mult_share_ctrl
package mult_share_pkg;
  localparam int MULT_W = 32;
  localparam int PROD_W = 64;
  localparam int ID_W = 3;
  typedef struct packed {
    logic valid;
    logic [ID_W-1:0] id;
    logic neg;
  } mult_tag_t;
  function automatic logic [MULT_W-1:0] abs32(input logic [MULT_W-1:0] x, input logic s);
    return (s && x[MULT_W-1]) ? -x : x;
  endfunction
endpackage

// File: rtl/mult_share_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, pointer holds the last granted index
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         accept_i,
  output logic [N-1:0] gnt_o
);
  logic [IW-1:0] ptr_q, ptr_d;
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    for (int k = 1; k <= N; k++) begin
      if (gnt_o == '0 && req_i[(int'(ptr_q) + k) % N]) begin
        gnt_o[(int'(ptr_q) + k) % N] = 1'b1;
        ptr_d = IW'((int'(ptr_q) + k) % N);
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) ptr_q <= IW'(N - 1);
    else if (accept_i) ptr_q <= ptr_d;
endmodule

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: arbitrates requesters onto one pipelined unsigned multiplier,
// converting signed operands to magnitudes and restoring the sign on the product
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MULT_LAT = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [MULT_W*NUM_REQ-1:0] req_a,
  input  logic [MULT_W*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_signed,
  output logic [MULT_W-1:0]         mult_a,
  output logic [MULT_W-1:0]         mult_b,
  input  logic [PROD_W-1:0]         mult_p,
  output logic                      resp_valid,
  output logic [IW-1:0]             resp_id,
  output logic [PROD_W-1:0]         resp_p,
  output logic                      busy
);
  logic [NUM_REQ-1:0] req_v;
  logic [MULT_W-1:0] sel_a, sel_b;
  logic sel_s;
  logic [ID_W-1:0] sel_id;
  mult_tag_t tag_d;
  mult_tag_t tag_q [MULT_LAT];
  logic resp_valid_q;
  logic [IW-1:0] resp_id_q;
  logic [PROD_W-1:0] resp_p_q;
  assign req_v = rst ? '0 : req_valid;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk(clk),
    .rst(rst),
    .req_i(req_v),
    .accept_i(|req_ready),
    .gnt_o(req_ready)
  );
  // idle cycles select zeros so the multiplier sees 0 and the tag stays invalid
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_s = 1'b0;
    sel_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_a = req_a[MULT_W*i +: MULT_W];
        sel_b = req_b[MULT_W*i +: MULT_W];
        sel_s = req_signed[i];
        sel_id = ID_W'(i);
      end
    end
  end
  assign mult_a = abs32(sel_a, sel_s);
  assign mult_b = abs32(sel_b, sel_s);
  assign tag_d = '{valid: |req_ready, id: sel_id, neg: sel_s & (sel_a[MULT_W-1] ^ sel_b[MULT_W-1])};
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MULT_LAT; k++) tag_q[k] <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q <= '0;
      resp_p_q <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int k = 1; k < MULT_LAT; k++) tag_q[k] <= tag_q[k-1];
      resp_valid_q <= tag_q[MULT_LAT-1].valid;
      resp_id_q <= IW'(tag_q[MULT_LAT-1].id);
      resp_p_q <= tag_q[MULT_LAT-1].neg ? -mult_p : mult_p;
    end
  end
  always_comb begin
    busy = resp_valid_q;
    for (int k = 0; k < MULT_LAT; k++) busy = busy | tag_q[k].valid;
  end
  assign resp_valid = resp_valid_q;
  assign resp_id = resp_id_q;
  assign resp_p = resp_p_q;
endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl: random and directed stimulus against a queue-based reference model
module tb_mult_share_ctrl;
  localparam int N = 4;
  localparam int L = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, req_signed = '0;
  logic [32*N-1:0] req_a = '0, req_b = '0;
  logic [31:0] mult_a, mult_b, ma_q, mb_q;
  logic [63:0] mult_p, resp_p, last_p;
  logic resp_valid, busy;
  logic [1:0] resp_id;
  int n_chk = 0, n_pass = 0, cyc = 0, ptr = N - 1;
  int resp_cnt = 0, last_cyc = 0, last_id = 0, last_issue = 0;
  typedef struct {
    int due;
    int id;
    logic [63:0] p;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  mult_share_ctrl #(.NUM_REQ(N), .MULT_LAT(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
    .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_p(resp_p), .busy(busy)
  );
  always_ff @(posedge clk)
    if (rst) begin
      ma_q <= '0;
      mb_q <= '0;
      mult_p <= '0;
    end else begin
      ma_q <= mult_a;
      mb_q <= mult_b;
      mult_p <= 64'(ma_q) * 64'(mb_q);
    end
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
  endtask
  function automatic logic [63:0] ref_mul(logic [31:0] a, logic [31:0] b, logic s);
    logic [63:0] xa, xb;
    xa = {{32{s & a[31]}}, a};
    xb = {{32{s & b[31]}}, b};
    return xa * xb;
  endfunction
  always @(negedge clk) begin
    logic [N-1:0] g;
    bit ev;
    int i;
    ev = q.size() > 0 && q[0].due == cyc;
    chk("resp_valid", {63'b0, resp_valid}, {63'b0, ev});
    if (ev) begin
      chk("resp_id", 64'(resp_id), 64'(q[0].id));
      chk("resp_p", resp_p, q[0].p);
      void'(q.pop_front());
    end
    if (resp_valid) begin
      resp_cnt++;
      last_cyc = cyc;
      last_p = resp_p;
      last_id = int'(resp_id);
    end
    chk("busy", {63'b0, busy}, {63'b0, ev || (q.size() > 0 && q[0].due <= cyc + L)});
    g = '0;
    if (!rst)
      for (int k = 1; k <= N; k++) begin
        i = (ptr + k) % N;
        if (g == '0 && req_valid[i]) g[i] = 1'b1;
      end
    chk("req_ready", 64'(req_ready), 64'(g));
    for (int k = 0; k < N; k++)
      if (g[k]) begin
        q.push_back('{cyc + L + 1, k, ref_mul(req_a[32*k +: 32], req_b[32*k +: 32], req_signed[k])});
        ptr = k;
      end
    if (rst) begin
      q.delete();
      ptr = N - 1;
    end
  end
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  task automatic do_reset(int n);
    @(posedge clk);
    #1 rst = 1'b1;
    req_valid = '0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic send(int i, logic [31:0] a, logic [31:0] b, logic s);
    @(posedge clk);
    #1 req_valid = '0;
    req_valid[i] = 1'b1;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_signed[i] = s;
    last_issue = cyc;
    @(posedge clk);
    #1 req_valid = '0;
  endtask
  task automatic expect_resp(string name, int id, logic [63:0] p);
    int c0 = resp_cnt;
    int k = 0;
    while (resp_cnt == c0 && k < 8) begin
      @(negedge clk);
      #1 k++;
    end
    chk({name, "_seen"}, 64'(resp_cnt - c0), 64'd1);
    chk({name, "_p"}, last_p, p);
    chk({name, "_id"}, 64'(last_id), 64'(id));
    chk({name, "_lat"}, 64'(last_cyc - last_issue), 64'(L + 1));
  endtask
  initial begin
    int c0;
    #1_000_000 $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end
  initial begin
    int c0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
    chk("rst_resp_p", resp_p, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    send(0, 32'd3, 32'd5, 1'b0);
    expect_resp("u3x5", 0, 64'd15);
    send(1, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    expect_resp("s_m1_min", 1, 64'h0000000080000000);
    send(2, 32'hFFFFFFF9, 32'd6, 1'b1);
    expect_resp("s_m7x6", 2, 64'hFFFFFFFFFFFFFFD6);
    send(3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    expect_resp("u_max", 3, 64'hFFFFFFFE00000001);
    send(0, 32'd0, 32'hFFFFFFFB, 1'b1);
    expect_resp("s_zero_neg", 0, 64'd0);
    do_reset(1);
    c0 = resp_cnt;
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) begin
        req_a[32*i +: 32] = pick();
        req_b[32*i +: 32] = pick();
        req_signed[i] = 1'($urandom);
      end
      #1 chk("grant_order", 64'(req_ready), 64'(1 << (k % N)));
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    repeat (L + 3) @(posedge clk);
    #1 chk("b2b_count", 64'(resp_cnt - c0), 64'd8);
    c0 = resp_cnt;
    @(posedge clk);
    #1 req_valid = 4'b0001;
    @(posedge clk);
    #1 req_valid = 4'b0010;
    @(posedge clk);
    #1 req_valid = '0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("rst_drop_count", 64'(resp_cnt - c0), 64'd0);
    chk("rst_drop_busy", {63'b0, busy}, 64'd0);
    send(3, 32'd1000, 32'hFFFFFFFE, 1'b1);
    expect_resp("post_rst", 3, 64'hFFFFFFFFFFFFF830);
    repeat (3000) begin
      @(posedge clk);
      #1 rst = ($urandom_range(0, 199) == 0);
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_a[32*i +: 32] = pick();
        req_b[32*i +: 32] = pick();
        req_signed[i] = 1'($urandom);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid = '0;
    repeat (L + 4) @(posedge clk);
    #1 chk("drain", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
